// File: rtl/joy_button_ctrl_if.sv
// Joystick pin bundle: raw active-low DB9 lines in, conditioned joystick and button signals out.
interface joy_button_ctrl_if;
  logic [11:0] n_joy;
  logic [5:0]  joy1;
  logic [5:0]  joy2;
  logic        btn_reset;
  logic        btn_nmi;
  logic        led_hold;

  modport master (
    output n_joy,
    input  joy1, joy2, btn_reset, btn_nmi, led_hold
  );

  modport slave (
    input  n_joy,
    output joy1, joy2, btn_reset, btn_nmi, led_hold
  );
endinterface

// File: rtl/joy_button_ctrl.sv
// DB9 joystick conditioner: sync + debounce, long-hold reset and NMI pulse from JOY2 fire buttons.
// Optional JOY1 autofire is built when JOY_AUTOFIRE_EN is defined.
module joy_button_ctrl #(
  parameter int unsigned C_clk_hz       = 50000000,
  parameter int unsigned C_debounce_ms  = 10,
  parameter int unsigned C_hold_ms      = 1000,
  parameter int unsigned C_pulse_cycles = 16,
  parameter int unsigned C_autofire_ms  = 50
) (
  input logic              clk_cpu,
  input logic              rst_n,
  joy_button_ctrl_if.slave bus
);

  localparam int unsigned TickDiv = (C_clk_hz / 1000 > 1) ? C_clk_hz / 1000 : 2;
  localparam int unsigned PreW    = $clog2(TickDiv);
  localparam int unsigned DbW     = $clog2(C_debounce_ms + 1);
  localparam int unsigned HoldW   = $clog2(C_hold_ms + 1);
  localparam int unsigned PulseW  = $clog2(C_pulse_cycles + 1);

  localparam logic [PreW-1:0]   PreMax    = PreW'(TickDiv - 1);
  localparam logic [DbW-1:0]    DbMax     = DbW'(C_debounce_ms);
  localparam logic [HoldW-1:0]  HoldMax   = HoldW'(C_hold_ms);
  localparam logic [PulseW-1:0] PulseLast = PulseW'(C_pulse_cycles - 1);

  typedef enum logic [1:0] {StIdle, StHold, StAssert} state_e;

  logic [11:0]     sync1_q, sync2_q, s, d_q;
  logic [PreW-1:0] pre_q;
  logic            tick;
  logic [DbW-1:0]  db_cnt_q [12];

  state_e          state_q;
  logic [HoldW-1:0] hold_cnt_q;
  logic            led_hold_q, btn_reset_q;

  logic            f1, f2, f2_q, nmi_trig, btn_nmi_q;
  logic [PulseW-1:0] nmi_cnt_q;
  logic            fire1_out;

  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= bus.n_joy;
      sync2_q <= sync1_q;
    end
  end

  assign s = ~sync2_q;

  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n)    pre_q <= '0;
    else if (tick) pre_q <= '0;
    else           pre_q <= pre_q + PreW'(1);
  end

  assign tick = (pre_q == PreMax);

  // Counter only advances while the line disagrees; any bounce back clears it.
  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) begin
      d_q <= '0;
      for (int i = 0; i < 12; i++) db_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 12; i++) begin
        if (s[i] == d_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DbMax) begin
          d_q[i]      <= s[i];
          db_cnt_q[i] <= '0;
        end else if (tick) begin
          db_cnt_q[i] <= db_cnt_q[i] + DbW'(1);
        end
      end
    end
  end

  assign f1 = d_q[11];
  assign f2 = d_q[10];

  // f1 can only be high in StIdle on the cycle it rises, so the level test acts as an edge.
  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      hold_cnt_q  <= '0;
      led_hold_q  <= 1'b0;
      btn_reset_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (f1) begin
            state_q    <= StHold;
            hold_cnt_q <= '0;
            led_hold_q <= 1'b1;
          end
        end
        StHold: begin
          if (!f1) begin
            state_q    <= StIdle;
            led_hold_q <= 1'b0;
          end else if (hold_cnt_q == HoldMax) begin
            state_q     <= StAssert;
            led_hold_q  <= 1'b0;
            btn_reset_q <= 1'b1;
          end else if (tick) begin
            hold_cnt_q <= hold_cnt_q + HoldW'(1);
          end
        end
        StAssert: begin
          if (!f1) begin
            state_q     <= StIdle;
            btn_reset_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // ~f1 drops an f2 edge that coincides with the f1 rise.
  assign nmi_trig = f2 & ~f2_q & ~f1 & (state_q == StIdle);

  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) begin
      f2_q      <= 1'b0;
      btn_nmi_q <= 1'b0;
      nmi_cnt_q <= '0;
    end else begin
      f2_q <= f2;
      if (btn_nmi_q) begin
        if (nmi_cnt_q == PulseLast) btn_nmi_q <= 1'b0;
        else                        nmi_cnt_q <= nmi_cnt_q + PulseW'(1);
      end else if (nmi_trig) begin
        btn_nmi_q <= 1'b1;
        nmi_cnt_q <= '0;
      end
    end
  end

`ifdef JOY_AUTOFIRE_EN
  localparam int unsigned AfW = $clog2(C_autofire_ms + 1);
  localparam logic [AfW-1:0] AfLast = AfW'(C_autofire_ms - 1);

  logic           af_held_q, af_phase_q;
  logic [AfW-1:0] af_cnt_q;

  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) begin
      af_held_q  <= 1'b0;
      af_phase_q <= 1'b0;
      af_cnt_q   <= '0;
    end else if (!d_q[4]) begin
      af_held_q  <= 1'b0;
      af_phase_q <= 1'b0;
      af_cnt_q   <= '0;
    end else if (!af_held_q) begin
      af_held_q  <= 1'b1;
      af_phase_q <= 1'b1;
      af_cnt_q   <= '0;
    end else if (tick) begin
      if (af_cnt_q == AfLast) begin
        af_cnt_q   <= '0;
        af_phase_q <= ~af_phase_q;
      end else begin
        af_cnt_q <= af_cnt_q + AfW'(1);
      end
    end
  end

  // High on the very first held cycle, before the phase register catches up.
  assign fire1_out = d_q[4] & (~af_held_q | af_phase_q);
`else
  logic unused_af_cfg;
  assign unused_af_cfg = ^C_autofire_ms;
  assign fire1_out     = d_q[4];
`endif

  assign bus.joy1      = {d_q[5], fire1_out, d_q[3:0]};
  assign bus.joy2      = d_q[11:6];
  assign bus.btn_reset = btn_reset_q;
  assign bus.btn_nmi   = btn_nmi_q;
  assign bus.led_hold  = led_hold_q;

endmodule

// File: tb/tb_joy_button_ctrl.sv
// Self-checking bench for joy_button_ctrl: vector table, randomized settle model, FSM/NMI sequences.
module tb_joy_button_ctrl;

  localparam int unsigned ClkHz = 8000;
  localparam int unsigned Deb   = 3;
  localparam int unsigned Hold  = 5;
  localparam int unsigned Pulse = 4;
  localparam int unsigned Af    = 2;

`ifdef JOY_AUTOFIRE_EN
  localparam logic [5:0] J1Mask = 6'b101111;
`else
  localparam logic [5:0] J1Mask = 6'b111111;
`endif

  logic clk_cpu = 1'b0;
  logic rst_n   = 1'b0;

  joy_button_ctrl_if bus();

  joy_button_ctrl #(
    .C_clk_hz      (ClkHz),
    .C_debounce_ms (Deb),
    .C_hold_ms     (Hold),
    .C_pulse_cycles(Pulse),
    .C_autofire_ms (Af)
  ) dut (
    .clk_cpu(clk_cpu),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 clk_cpu = ~clk_cpu;

  int n_vec = 0;
  int n_bad = 0;

  logic [11:0] mon_exp  = 12'h0;
  logic [11:0] mon_mask = 12'h0;
  bit          mon_en   = 1'b0;
  int          mon_viol = 0;

  typedef struct {
    logic [11:0] n_joy;
    int          cycles;
    logic [5:0]  joy1;
    logic [5:0]  joy2;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk_cpu);
      if (mon_en && ((({bus.joy2, bus.joy1} ^ ~mon_exp) & mon_mask) != 12'h0)) mon_viol++;
    end
  endtask

  task automatic outs_zero(input string name);
    check(name, {bus.joy2, bus.joy1, bus.btn_reset, bus.btn_nmi, bus.led_hold}, 32'h0);
  endtask

  int          k;
  int          cnt;
  int          saw;
  logic [11:0] prev_t, new_t, stable, gm;

  initial begin
    tbl[0] = '{12'hFFF,  4, 6'h00, 6'h00};
    tbl[1] = '{12'hFFE, 40, 6'h01, 6'h00};
    tbl[2] = '{12'hFFF, 40, 6'h00, 6'h00};
    tbl[3] = '{12'hFC0, 40, 6'h3F, 6'h00};
    tbl[4] = '{12'hC3F, 40, 6'h00, 6'h0F};
    tbl[5] = '{12'hEAA, 40, 6'h15, 6'h05};
    tbl[6] = '{12'hD55, 40, 6'h2A, 6'h0A};
    tbl[7] = '{12'hFFF, 40, 6'h00, 6'h00};

    bus.n_joy = 12'hFFF;
    step(3);
    outs_zero("reset_state");
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      bus.n_joy = tbl[i].n_joy;
      step(tbl[i].cycles);
      check($sformatf("tbl%0d_joy1", i), bus.joy1 & J1Mask, tbl[i].joy1 & J1Mask);
      check($sformatf("tbl%0d_joy2", i), bus.joy2, tbl[i].joy2);
      check($sformatf("tbl%0d_btn", i), {bus.btn_reset, bus.btn_nmi, bus.led_hold}, 3'b000);
    end

    // Press/release latency: 2 sync cycles + 3 ticks, allowing one tick either way.
    bus.n_joy = 12'hFFE;
    k = 0;
    while (bus.joy1[0] !== 1'b1 && k < 60) begin step(1); k++; end
    check("press_latency", (k >= 18 && k <= 34), 1);
    step(10);
    bus.n_joy = 12'hFFF;
    k = 0;
    while (bus.joy1[0] !== 1'b0 && k < 60) begin step(1); k++; end
    check("release_latency", (k >= 18 && k <= 34), 1);

    // Repeated 10-cycle bounces on n_joy[3] never reach the output.
    mon_exp = 12'hFFF; mon_mask = 12'h008; mon_viol = 0; mon_en = 1'b1;
    for (int r = 0; r < 8; r++) begin
      bus.n_joy = 12'hFF7; step(10);
      bus.n_joy = 12'hFFF; step(3);
    end
    step(30);
    mon_en = 1'b0;
    check("bounce_rejected", mon_viol, 0);

    // Random patterns: settled outputs follow the pins, untouched bits survive short glitches.
    prev_t = 12'hFFF;
    for (int it = 0; it < 20; it++) begin
      new_t    = 12'($urandom & 32'h3FF) | 12'hC00;
      stable   = ~(new_t ^ prev_t) & 12'h3FF;
      mon_exp  = prev_t;
      mon_mask = stable & {6'h3F, J1Mask};
      mon_viol = 0;
      mon_en   = 1'b1;
      bus.n_joy = new_t;
      for (int g = 0; g < 3; g++) begin
        gm = (12'h1 << $urandom_range(9, 0)) & stable;
        bus.n_joy = new_t ^ gm;
        step(int'($urandom_range(10, 1)));
        bus.n_joy = new_t;
        step(int'($urandom_range(5, 2)));
      end
      step(50);
      mon_en = 1'b0;
      check($sformatf("rand%0d_joy", it), {bus.joy2, bus.joy1} & {6'h3F, J1Mask},
            ~new_t & {6'h3F, J1Mask});
      check($sformatf("rand%0d_stable", it), mon_viol, 0);
      prev_t = new_t;
    end
    bus.n_joy = 12'hFFF;
    step(50);

    // Long fire1 hold: led_hold, then btn_reset, then release.
    bus.n_joy = 12'h7FF;
    k = 0;
    while (bus.joy2[5] !== 1'b1 && k < 60) begin step(1); k++; end
    check("f1_debounced", k < 60, 1);
    check("led_lags_f1", bus.led_hold, 0);
    step(1);
    check("led_on", bus.led_hold, 1);
    k = 0;
    while (bus.btn_reset !== 1'b1 && k < 80) begin step(1); k++; end
    check("hold_time", (k >= 32 && k <= 42), 1);
    check("led_off_in_assert", bus.led_hold, 0);
    step(20);
    check("reset_held", bus.btn_reset, 1);
    bus.n_joy = 12'hFFF;
    k = 0;
    while (bus.joy2[5] !== 1'b0 && k < 60) begin step(1); k++; end
    check("f1_release_seen", k < 60, 1);
    check("reset_still_on", bus.btn_reset, 1);
    step(1);
    check("reset_off", bus.btn_reset, 0);
    step(40);

    // Short hold (3 ticks): led_hold flashes, btn_reset never fires.
    bus.n_joy = 12'h7FF;
    saw = 0; cnt = 0;
    for (int c = 0; c < 24; c++) begin
      step(1);
      if (bus.led_hold) saw = 1;
      if (bus.btn_reset) cnt++;
    end
    bus.n_joy = 12'hFFF;
    for (int c = 0; c < 60; c++) begin
      step(1);
      if (bus.led_hold) saw = 1;
      if (bus.btn_reset) cnt++;
    end
    check("short_hold_led_seen", saw, 1);
    check("short_hold_no_reset", cnt, 0);
    check("short_hold_led_off", bus.led_hold, 0);

    // NMI pulse: exact width, no retrigger while held.
    bus.n_joy = 12'hBFF;
    k = 0;
    while (bus.joy2[4] !== 1'b1 && k < 60) begin step(1); k++; end
    check("f2_debounced", k < 60, 1);
    check("nmi_lags_f2", bus.btn_nmi, 0);
    cnt = 0;
    for (int c = 0; c < 30; c++) begin step(1); if (bus.btn_nmi) cnt++; end
    check("nmi_width", cnt, Pulse);
    bus.n_joy = 12'hFFF;
    cnt = 0;
    for (int c = 0; c < 50; c++) begin step(1); if (bus.btn_nmi) cnt++; end
    check("nmi_none_on_release", cnt, 0);

    // fire2 press during HOLD is dropped.
    bus.n_joy = 12'h7FF;
    k = 0;
    while (bus.led_hold !== 1'b1 && k < 60) begin step(1); k++; end
    check("hold_entered", k < 60, 1);
    bus.n_joy = 12'h3FF;
    k = 0; cnt = 0;
    while (bus.joy2[4] !== 1'b1 && k < 60) begin step(1); k++; if (bus.btn_nmi) cnt++; end
    for (int c = 0; c < 20; c++) begin step(1); if (bus.btn_nmi) cnt++; end
    check("nmi_dropped_in_hold", cnt, 0);
    bus.n_joy = 12'hFFF;
    step(50);

    // Simultaneous fire1/fire2 rise: reset path wins.
    bus.n_joy = 12'h3FF;
    k = 0;
    while (bus.joy2[5:4] !== 2'b11 && k < 60) begin step(1); k++; end
    cnt = 0;
    for (int c = 0; c < 20; c++) begin step(1); if (bus.btn_nmi) cnt++; end
    check("simul_no_nmi", cnt, 0);
    check("simul_hold", bus.led_hold | bus.btn_reset, 1);
    bus.n_joy = 12'hFFF;
    step(50);

    // Asynchronous reset mid NMI pulse.
    bus.n_joy = 12'hBFE;
    k = 0;
    while (bus.btn_nmi !== 1'b1 && k < 80) begin step(1); k++; end
    check("pulse_before_rst", {bus.btn_nmi, bus.joy1[0]}, 2'b11);
    #2 rst_n = 1'b0;
    #1 outs_zero("async_rst_mid_pulse");
    bus.n_joy = 12'hFFF;
    step(3);
    rst_n = 1'b1;
    step(40);

    // Asynchronous reset mid HOLD.
    bus.n_joy = 12'h7FF;
    k = 0;
    while (bus.led_hold !== 1'b1 && k < 60) begin step(1); k++; end
    step(10);
    check("hold_before_rst", {bus.led_hold, bus.joy2[5]}, 2'b11);
    #2 rst_n = 1'b0;
    #1 outs_zero("async_rst_mid_hold");
    bus.n_joy = 12'hFFF;
    step(3);
    rst_n = 1'b1;
    step(40);

`ifdef JOY_AUTOFIRE_EN
    bus.n_joy = 12'hFEF;
    k = 0;
    while (bus.joy1[4] !== 1'b1 && k < 60) begin step(1); k++; end
    check("af_first_high", k < 60, 1);
    k = 0;
    while (bus.joy1[4] !== 1'b0 && k < 40) begin step(1); k++; end
    check("af_half_period", (k >= 8 && k <= 17), 1);
    k = 0;
    while (bus.joy1[4] !== 1'b1 && k < 40) begin step(1); k++; end
    check("af_full_half", (k >= 15 && k <= 17), 1);
    bus.n_joy = 12'hFFF;
    step(40);
    check("af_release", bus.joy1[4], 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
